// File: rtl/alu_arbiter.sv
// Purpose : two-requester round-robin arbiter sharing one ALU, result held in a
//           one-entry output register tagged with the requester ID.
// Latency : 1 cycle from request handshake to result on res_*.
// Backpr. : requests are accepted only when the output entry is empty or being
//           drained this cycle; a stalled result holds and both readies drop.
//
// Ports (alu_arbiter):
//   clk_i, rst_i                         clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o          request handshake for requester N (N=0,1)
//   reqN_srcA_i, reqN_srcB_i             operands for requester N
//   reqN_ALUCtrl_i                       4-bit opcode for requester N
//   res_valid_o / res_ready_i            result handshake
//   res_data_o, res_id_o                 registered result and producing requester

// Purpose : combinational integer ALU (ADD..SRA), unused opcodes return 0.
// Latency : 0 cycles, purely combinational.
// Backpr. : none; no handshake.
//
// Ports (alu):
//   src_a, src_b   operands; shift amount is src_b[SHIFT_WIDTH-1:0]
//   alu_ctrl       opcode
//   result         operation result, modulo 2^DATA_WIDTH
module alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [3:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  logic [SHIFT_WIDTH-1:0] shamt;
  logic                   lt_signed;
  logic                   lt_unsigned;

  assign shamt       = src_b[SHIFT_WIDTH-1:0];
  assign lt_signed   = $signed(src_a) < $signed(src_b);
  assign lt_unsigned = src_a < src_b;

  always_comb begin
    result = '0;
    case (alu_ctrl)
      OP_ADD:  result = src_a + src_b;
      OP_SUB:  result = src_a - src_b;
      OP_AND:  result = src_a & src_b;
      OP_OR:   result = src_a | src_b;
      OP_XOR:  result = src_a ^ src_b;
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
      OP_SRL:  result = src_a >> shamt;
      OP_SLL:  result = src_a << shamt;
      OP_SRA:  result = $unsigned($signed(src_a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_srcA_i,
  input  logic [DATA_WIDTH-1:0] req0_srcB_i,
  input  logic [3:0]            req0_ALUCtrl_i,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_srcA_i,
  input  logic [DATA_WIDTH-1:0] req1_srcB_i,
  input  logic [3:0]            req1_ALUCtrl_i,

  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_id_o
);

  typedef struct packed {
    logic [3:0]            ctrl;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
  } req_t;

  req_t                  req0;
  req_t                  req1;
  req_t                  sel_req;
  logic                  last_grant;
  logic                  grant;
  logic                  any_valid;
  logic                  can_accept;
  logic                  fire;
  logic [DATA_WIDTH-1:0] alu_result;

  assign req0 = '{ctrl: req0_ALUCtrl_i, src_a: req0_srcA_i, src_b: req0_srcB_i};
  assign req1 = '{ctrl: req1_ALUCtrl_i, src_a: req1_srcA_i, src_b: req1_srcB_i};

  // Output entry frees up either because it is empty or because the consumer
  // is taking it this very cycle, so drain and refill can share one edge.
  assign can_accept = !res_valid_o || res_ready_i;
  assign any_valid  = req0_valid_i || req1_valid_i;

  // Lone requester wins outright; under contention the one that did not win
  // last time goes next.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_grant;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  assign fire         = can_accept && any_valid && !rst_i;
  assign req0_ready_o = fire && (grant == 1'b0) && req0_valid_i;
  assign req1_ready_o = fire && (grant == 1'b1) && req1_valid_i;

  assign sel_req = grant ? req1 : req0;

  alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_alu (
    .src_a    (sel_req.src_a),
    .src_b    (sel_req.src_b),
    .alu_ctrl (sel_req.ctrl),
    .result   (alu_result)
  );

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_id_o    <= 1'b0;
      last_grant  <= 1'b1;
    end else if (fire) begin
      res_valid_o <= 1'b1;
      res_data_o  <= alu_result;
      res_id_o    <= grant;
      last_grant  <= grant;
    end else if (res_valid_o && res_ready_i) begin
      // Drained with nothing to refill: data/id keep their last values.
      res_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : directed self-checking bench for alu_arbiter.
// Latency : n/a (testbench).
// Backpr. : drives res_ready_i low to exercise stall behaviour.
module tb_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req0_ready_o;
  logic [31:0] req0_srcA_i, req0_srcB_i;
  logic [3:0]  req0_ALUCtrl_i;
  logic        req1_valid_i, req1_ready_o;
  logic [31:0] req1_srcA_i, req1_srcB_i;
  logic [3:0]  req1_ALUCtrl_i;
  logic        res_valid_o, res_ready_i;
  logic [31:0] res_data_o;
  logic        res_id_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] op_exp [16];

  always #5 clk_i = ~clk_i;

  alu_arbiter #(.DATA_WIDTH(32), .SHIFT_WIDTH(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req0_valid_i   (req0_valid_i),
    .req0_ready_o   (req0_ready_o),
    .req0_srcA_i    (req0_srcA_i),
    .req0_srcB_i    (req0_srcB_i),
    .req0_ALUCtrl_i (req0_ALUCtrl_i),
    .req1_valid_i   (req1_valid_i),
    .req1_ready_o   (req1_ready_o),
    .req1_srcA_i    (req1_srcA_i),
    .req1_srcB_i    (req1_srcB_i),
    .req1_ALUCtrl_i (req1_ALUCtrl_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_data_o     (res_data_o),
    .res_id_o       (res_id_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // A = 0xFFFFFFF0, B = 0x00000021, shift amount 1.
    op_exp[0]  = 32'h0000_0011; // ADD
    op_exp[1]  = 32'hFFFF_FFCF; // SUB
    op_exp[2]  = 32'h0000_0020; // AND
    op_exp[3]  = 32'hFFFF_FFF1; // OR
    op_exp[4]  = 32'hFFFF_FFD1; // XOR
    op_exp[5]  = 32'h0000_0001; // SLT
    op_exp[6]  = 32'h0000_0000; // SLTU
    op_exp[7]  = 32'h7FFF_FFF8; // SRL
    op_exp[8]  = 32'hFFFF_FFE0; // SLL
    op_exp[9]  = 32'hFFFF_FFF8; // SRA
    for (int k = 10; k < 16; k++) op_exp[k] = 32'h0;

    // Reset for 2 edges with both requesters valid.
    rst_i = 1'b1; res_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_srcA_i = 32'd1;  req0_srcB_i = 32'd2;  req0_ALUCtrl_i = 4'd0;
    req1_valid_i = 1'b1; req1_srcA_i = 32'd10; req1_srcB_i = 32'd20; req1_ALUCtrl_i = 4'd0;
    #1;
    check("rst_ready0_pre", {31'b0, req0_ready_o}, 32'd0);
    check("rst_ready1_pre", {31'b0, req1_ready_o}, 32'd0);
    tick();
    tick();
    check("rst_ready0", {31'b0, req0_ready_o}, 32'd0);
    check("rst_ready1", {31'b0, req1_ready_o}, 32'd0);
    check("rst_valid",  {31'b0, res_valid_o},  32'd0);
    check("rst_data",   res_data_o,            32'd0);
    check("rst_id",     {31'b0, res_id_o},     32'd0);

    // Release: requester 0 wins first contention.
    rst_i = 1'b0;
    #1;
    check("first_ready0", {31'b0, req0_ready_o}, 32'd1);
    check("first_ready1", {31'b0, req1_ready_o}, 32'd0);
    tick();
    check("first_valid", {31'b0, res_valid_o}, 32'd1);
    check("first_id",    {31'b0, res_id_o},    32'd0);
    check("first_data",  res_data_o,           32'd3);

    // Single requester 1: SUB 5-7.
    req0_valid_i = 1'b0;
    req1_srcA_i = 32'd5; req1_srcB_i = 32'd7; req1_ALUCtrl_i = 4'd1;
    #1;
    check("single_ready1", {31'b0, req1_ready_o}, 32'd1);
    check("single_ready0", {31'b0, req0_ready_o}, 32'd0);
    tick();
    check("single_valid", {31'b0, res_valid_o}, 32'd1);
    check("single_id",    {31'b0, res_id_o},    32'd1);
    check("single_data",  res_data_o,           32'hFFFF_FFFE);

    // Contention: ADD 1+2 vs SRA 0x80000000>>>4; last grant was 1.
    req0_valid_i = 1'b1; req0_srcA_i = 32'd1; req0_srcB_i = 32'd2; req0_ALUCtrl_i = 4'd0;
    req1_srcA_i = 32'h8000_0000; req1_srcB_i = 32'd4; req1_ALUCtrl_i = 4'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ready0", {31'b0, req0_ready_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_ready1", {31'b0, req1_ready_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check("cont_valid", {31'b0, res_valid_o}, 32'd1);
      check("cont_id",    {31'b0, res_id_o},    (i % 2 == 1) ? 32'd1 : 32'd0);
      check("cont_data",  res_data_o,           (i % 2 == 1) ? 32'hF800_0000 : 32'd3);
    end

    // Backpressure: pending result (id 1, 0xF8000000) must hold for 3 cycles.
    res_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", {31'b0, req0_ready_o}, 32'd0);
      check("bp_ready1", {31'b0, req1_ready_o}, 32'd0);
      tick();
      check("bp_valid", {31'b0, res_valid_o}, 32'd1);
      check("bp_id",    {31'b0, res_id_o},    32'd1);
      check("bp_data",  res_data_o,           32'hF800_0000);
    end
    // Release: same-cycle drain and refill, requester 0 next.
    res_ready_i = 1'b1;
    #1;
    check("bp_rel_ready0", {31'b0, req0_ready_o}, 32'd1);
    tick();
    check("bp_rel_valid", {31'b0, res_valid_o}, 32'd1);
    check("bp_rel_id",    {31'b0, res_id_o},    32'd0);
    check("bp_rel_data",  res_data_o,           32'd3);

    // Opcode sweep on requester 0.
    req1_valid_i = 1'b0;
    req0_srcA_i = 32'hFFFF_FFF0; req0_srcB_i = 32'h0000_0021;
    for (int op = 0; op < 16; op++) begin
      req0_ALUCtrl_i = op[3:0];
      tick();
      check($sformatf("op%0d_data", op), res_data_o, op_exp[op]);
      check($sformatf("op%0d_id", op), {31'b0, res_id_o}, 32'd0);
    end

    // Mid-pending reset: last_grant is 0 here, reset must restore it to 1.
    res_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_srcA_i = 32'd1; req0_srcB_i = 32'd2; req0_ALUCtrl_i = 4'd0;
    req1_valid_i = 1'b1;
    rst_i = 1'b1;
    #1;
    check("mrst_ready0", {31'b0, req0_ready_o}, 32'd0);
    check("mrst_ready1", {31'b0, req1_ready_o}, 32'd0);
    tick();
    check("mrst_valid", {31'b0, res_valid_o}, 32'd0);
    check("mrst_data",  res_data_o,           32'd0);
    rst_i = 1'b0; res_ready_i = 1'b1;
    #1;
    check("mrst_ready0_rel", {31'b0, req0_ready_o}, 32'd1);
    check("mrst_ready1_rel", {31'b0, req1_ready_o}, 32'd0);
    tick();
    check("mrst_id",   {31'b0, res_id_o}, 32'd0);
    check("mrst_res",  res_data_o,        32'd3);

    // Drain without refill: valid drops, data/id held.
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();
    check("drain_valid", {31'b0, res_valid_o}, 32'd0);
    check("drain_data",  res_data_o,           32'd3);
    check("drain_id",    {31'b0, res_id_o},    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares one `ALU` instance between two clients, such as an integer pipe and an address/branch helper. It accepts operand/opcode requests over valid/ready handshakes and grants one per cycle. The selected request goes through the shared `ALU`, and the result is captured in a one-entry output register tagged with the requester ID. The result is returned over a valid/ready handshake that supports backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; passed to the internal `ALU`.
- `SHIFT_WIDTH`, 5, shift-amount width; passed to the internal `ALU`.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req0_valid_i`  in  1  requester 0 has a request.
- `req0_ready_o`  out  1  requester 0 request accepted this cycle.
- `req0_srcA_i`, `req0_srcB_i`  in  `DATA_WIDTH`  requester 0 operands.
- `req0_ALUCtrl_i`  in  4  requester 0 ALU opcode.
- `req1_valid_i`, `req1_ready_o`, `req1_srcA_i`, `req1_srcB_i`, `req1_ALUCtrl_i`: same as requester 0, for requester 1.
- `res_valid_o`  out  1  output register holds a result.
- `res_ready_i`  in  1  consumer takes the result this cycle.
- `res_data_o`  out  `DATA_WIDTH`  ALU result.
- `res_id_o`  out  1  ID of the requester that produced `res_data_o`.

## Operation
- **Shared `ALU`:** one internal `ALU` instance; its inputs are muxed from the granted requester.
- **Opcodes:** 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SRL, 1000 SLL, 1001 SRA.
  - Codes 1010–1111 are legal to issue and produce result 0.
  - The shift amount is `srcB[SHIFT_WIDTH-1:0]`.
- **Output buffer:** one entry, with `res_valid_o`/`res_data_o`/`res_id_o` as the registered state.
- **Accept condition:** `can_accept = !res_valid_o || res_ready_i`. A drain and a fill in the same cycle are allowed, which gives full throughput.
- **Arbitration:**
  - State is a `last_grant` register, 1 bit.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester ≠ `last_grant` is granted.
  - Neither valid: no grant.
- **Ready outputs:** `reqN_ready_o = can_accept && grant==N && reqN_valid_i && !rst_i`. They are combinational from valids, `res_valid_o`, `res_ready_i` and `last_grant`. At most one ready is high per cycle.
- **On a handshake** (`reqN_valid_i && reqN_ready_o`), at the next edge:
  - `res_data_o` ← `ALU` result of requester N's operands.
  - `res_id_o` ← N; `res_valid_o` ← 1; `last_grant` ← N.
- **Drain without refill:** `res_valid_o && res_ready_i` with no accepted request: `res_valid_o` ← 0. `res_data_o`/`res_id_o` hold their last values.
- **Stall:** `res_valid_o && !res_ready_i`. `res_data_o`, `res_id_o` and `res_valid_o` hold stable, both readies are 0, and `last_grant` holds.
- **Requester obligations:** a requester holds valid and its operands stable until ready. The arbiter does not depend on this beyond the current cycle.
- **Fairness:** a continuously-valid requester is granted within 2 accept opportunities.

## Timing
- **Latency:** request handshake at edge k; result visible on `res_*` after edge k, i.e. 1 cycle. The `ALU` path is combinational between the input mux and the output register.
- **Throughput:** 1 result/cycle while `res_ready_i` = 1.
- **Reset values (edge with `rst_i`=1):**
  - `res_valid_o`=0, `res_data_o`=0, `res_id_o`=0.
  - `last_grant`=1, so requester 0 wins the first contention.
  - `req0_ready_o`/`req1_ready_o` are forced 0 during any cycle with `rst_i`=1.
- **Reset mid-operation:** a pending unconsumed result is discarded, and no request is accepted in the reset cycle. A `res_ready_i` in the reset cycle has no effect.
- **Simultaneous drain+fill:** the new result replaces the old one at the same edge, and `res_valid_o` stays 1.
- **Width:** all arithmetic is modulo 2^`DATA_WIDTH`; SLT/SLTU results are zero-extended 0/1.

## Test plan
- **Reset:** hold `rst_i` 2 cycles with both valids high → readies 0, `res_valid_o`=0, `res_data_o`=0. Release → requester 0 granted first (`res_id_o`=0).
- **Single requester:** req1 only, SUB, A=5, B=7, `res_ready_i`=1 → 1 cycle later `res_valid_o`=1, `res_data_o`=0xFFFFFFFE, `res_id_o`=1.
- **Contention:** both requesters continuously valid, `res_ready_i`=1.
  - Requester 0 ADD 1+2; requester 1 SRA A=0x80000000, B=4.
  - Required grants 0,1,0,1…; results 3, 0xF8000000 alternating every cycle.
- **Backpressure:** `res_ready_i`=0 for 3 cycles while a result is pending → outputs stable and both readies 0. Raise `res_ready_i` → same-cycle refill of the next request, `res_valid_o` stays 1.
- **Opcodes:** sweep all 16 opcodes on requester 0 with A=0xFFFFFFF0, B=0x00000021.
  - SLT=1, SLTU=0, SLL=0xFFFFFFE0 (shift 1), 1010–1111 → 0.
  - Compare all results against the `ALU` model.
- **Mid-pending reset:** assert `rst_i` while `res_valid_o`=1 and `res_ready_i`=0 → next cycle `res_valid_o`=0, result lost, and the first grant after release goes to requester 0.
